// File: rtl/mem_req_buffer.sv
// Request-side front end of the data cache: validates and classifies memory-op
// commands, then buffers them in an in-order FIFO with fence draining.
module mem_req_buffer #(
    parameter int DEPTH         = 4,
    parameter int ADDR_W        = 40,
    parameter int DATA_W        = 64,
    parameter int TAG_W         = 8,
    parameter int DROP_PREFETCH = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [4:0]                   req_cmd,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [DATA_W-1:0]            req_data,
    input  logic [DATA_W/8-1:0]          req_mask,
    input  logic [TAG_W-1:0]             req_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [4:0]                   out_cmd,
    output logic [ADDR_W-1:0]            out_addr,
    output logic [DATA_W-1:0]            out_data,
    output logic [DATA_W/8-1:0]          out_mask,
    output logic [TAG_W-1:0]             out_tag,
    output logic                         out_is_read,
    output logic                         out_is_write,
    output logic                         out_is_amo,
    output logic                         out_is_prefetch,
    output logic                         out_is_write_intent,
    output logic                         nack_valid,
    output logic [TAG_W-1:0]             nack_tag,
    output logic                         pf_dropped,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int MW = DATA_W / 8;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [4:0] M_XRD       = 5'b00000;
    localparam logic [4:0] M_XWR       = 5'b00001;
    localparam logic [4:0] M_PFR       = 5'b00010;
    localparam logic [4:0] M_PFW       = 5'b00011;
    localparam logic [4:0] M_XA_SWAP   = 5'b00100;
    localparam logic [4:0] M_FLUSH_ALL = 5'b00101;
    localparam logic [4:0] M_XLR       = 5'b00110;
    localparam logic [4:0] M_XSC       = 5'b00111;
    localparam logic [4:0] M_PWR       = 5'b10001;
    localparam logic [4:0] M_SFENCE    = 5'b10100;

    typedef enum logic {RUN, FENCE} state_t;

    // flags packed as {read, write, amo, prefetch, write_intent}
    typedef struct packed {
        logic [4:0]        cmd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [MW-1:0]     mask;
        logic [TAG_W-1:0]  tag;
        logic [4:0]        flags;
    } entry_t;

    function automatic logic [4:0] classify(input logic [4:0] cmd);
        logic amo, rd, wr, pf, wint;
        amo  = (cmd == M_XA_SWAP) || (cmd[4:3] == 2'b01);
        rd   = (cmd == M_XRD) || (cmd == M_XLR) || (cmd == M_XSC) || amo;
        wr   = (cmd == M_XWR) || (cmd == M_PWR) || (cmd == M_XSC) || amo;
        pf   = (cmd == M_PFR) || (cmd == M_PFW);
        wint = wr || (cmd == M_PFW) || (cmd == M_XLR);
        return {rd, wr, amo, pf, wint};
    endfunction

    function automatic logic is_legal(input logic [4:0] cmd);
        return !((cmd[4:3] == 2'b11) || (cmd == 5'b10101) || (cmd == 5'b10110));
    endfunction

    function automatic logic is_fence(input logic [4:0] cmd);
        return (cmd == M_FLUSH_ALL) || (cmd == M_SFENCE);
    endfunction

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    state_t          state_reg, state_next;

    logic [4:0]      req_flags;
    logic            req_legal, req_fire, req_drop, enq, deq;
    entry_t          req_entry, head;

    assign req_flags = classify(req_cmd);
    assign req_legal = is_legal(req_cmd);
    assign req_ready = (state_reg == RUN) && (count_reg < FULL_COUNT);
    assign req_fire  = req_valid && req_ready;
    assign req_drop  = (DROP_PREFETCH != 0) && req_flags[1];
    assign enq       = req_fire && req_legal && !req_drop;
    assign req_entry = {req_cmd, req_addr, req_data, req_mask, req_tag, req_flags};

    assign head      = mem[rd_ptr_reg];
    assign out_valid = (count_reg != '0);
    assign deq       = out_valid && out_ready;
    assign count     = count_reg;

    // Head fields are forced to zero when empty so reset clears them without clearing storage.
    assign out_cmd  = out_valid ? head.cmd  : '0;
    assign out_addr = out_valid ? head.addr : '0;
    assign out_data = out_valid ? head.data : '0;
    assign out_mask = out_valid ? head.mask : '0;
    assign out_tag  = out_valid ? head.tag  : '0;
    assign {out_is_read, out_is_write, out_is_amo, out_is_prefetch, out_is_write_intent} =
        out_valid ? head.flags : 5'b0;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (enq && is_fence(req_cmd)) state_next = FENCE;
            // Nothing can be enqueued behind a fence, so its departure empties the FIFO.
            FENCE:   if (deq && is_fence(head.cmd)) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= RUN;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            nack_valid <= 1'b0;
            nack_tag   <= '0;
            pf_dropped <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (enq) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (deq) rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({enq, deq})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            nack_valid <= req_fire && !req_legal;
            nack_tag   <= (req_fire && !req_legal) ? req_tag : '0;
            pf_dropped <= req_fire && req_legal && req_drop;
        end
    end

    always_ff @(posedge clock) begin
        if (enq) mem[wr_ptr_reg] <= req_entry;
    end

endmodule

// File: tb/tb_mem_req_buffer.sv
// Directed bench for mem_req_buffer: a vector table for classification and
// flow, plus hand sequences for full, fence, prefetch drop and async reset.
module tb_mem_req_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [4:0]  req_cmd;
    logic [39:0] req_addr;
    logic [63:0] req_data;
    logic [7:0]  req_mask, req_tag;
    logic        out_valid, out_ready;
    logic [4:0]  out_cmd;
    logic [39:0] out_addr;
    logic [63:0] out_data;
    logic [7:0]  out_mask, out_tag;
    logic        out_is_read, out_is_write, out_is_amo, out_is_prefetch, out_is_write_intent;
    logic        nack_valid;
    logic [7:0]  nack_tag;
    logic        pf_dropped;
    logic [2:0]  count;

    logic        pf_req_valid, pf_req_ready, pf_out_valid;
    logic        pf_out_ready = 1'b1;
    logic [4:0]  pf_out_cmd;
    logic [39:0] pf_out_addr;
    logic [63:0] pf_out_data;
    logic [7:0]  pf_out_mask, pf_out_tag, pf_nack_tag;
    logic        pf_rd, pf_wr, pf_amo, pf_pf, pf_wint, pf_nack_valid, pf_pf_dropped;
    logic [2:0]  pf_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mem_req_buffer dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask), .req_tag(req_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_cmd(out_cmd),
        .out_addr(out_addr), .out_data(out_data), .out_mask(out_mask), .out_tag(out_tag),
        .out_is_read(out_is_read), .out_is_write(out_is_write), .out_is_amo(out_is_amo),
        .out_is_prefetch(out_is_prefetch), .out_is_write_intent(out_is_write_intent),
        .nack_valid(nack_valid), .nack_tag(nack_tag), .pf_dropped(pf_dropped), .count(count)
    );

    mem_req_buffer #(.DROP_PREFETCH(1)) dut_pf (
        .clock(clock), .reset(reset),
        .req_valid(pf_req_valid), .req_ready(pf_req_ready), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask), .req_tag(req_tag),
        .out_valid(pf_out_valid), .out_ready(pf_out_ready), .out_cmd(pf_out_cmd),
        .out_addr(pf_out_addr), .out_data(pf_out_data), .out_mask(pf_out_mask), .out_tag(pf_out_tag),
        .out_is_read(pf_rd), .out_is_write(pf_wr), .out_is_amo(pf_amo),
        .out_is_prefetch(pf_pf), .out_is_write_intent(pf_wint),
        .nack_valid(pf_nack_valid), .nack_tag(pf_nack_tag), .pf_dropped(pf_pf_dropped), .count(pf_count)
    );

    typedef struct {
        logic        v;
        logic [4:0]  cmd;
        logic [39:0] addr;
        logic [7:0]  tag;
        logic        ordy;
        logic        e_valid;
        logic [4:0]  e_cmd;
        logic [7:0]  e_tag;
        logic [4:0]  e_flags;
        logic [39:0] e_addr;
        logic [2:0]  e_count;
        logic        e_rdy;
        logic        e_nack;
        logic [7:0]  e_ntag;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Data and mask are derived from the tag so stored payload can be checked at the head.
    task automatic step(input logic v, input logic [4:0] cmd, input logic [39:0] addr,
                        input logic [7:0] tag, input logic ordy);
        req_valid = v;
        req_cmd   = cmd;
        req_addr  = addr;
        req_tag   = tag;
        req_data  = 64'hD000_0000 | {56'd0, tag};
        req_mask  = tag;
        out_ready = ordy;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [4:0] flags();
        return {out_is_read, out_is_write, out_is_amo, out_is_prefetch, out_is_write_intent};
    endfunction

    initial begin
        reset = 1'b1;
        req_valid = 0; req_cmd = 0; req_addr = 0; req_data = 0; req_mask = 0; req_tag = 0;
        out_ready = 0; pf_req_valid = 0;
        #3;
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_count", {61'd0, count}, 64'd0);
        check("rst_out_tag", {56'd0, out_tag}, 64'd0);
        check("rst_out_cmd", {59'd0, out_cmd}, 64'd0);
        check("rst_flags", {59'd0, flags()}, 64'd0);
        check("rst_nack", {63'd0, nack_valid}, 64'd0);
        check("rst_pf_dropped", {63'd0, pf_pf_dropped}, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        //            v  cmd       addr        tag   ordy  ev cmd       etag  flags     eaddr       cnt rdy nk ntag
        tbl.push_back('{1, 5'b01000, 40'h1010, 8'h10, 0,  1, 5'b01000, 8'h10, 5'b11101, 40'h1010, 3'd1, 1, 0, 8'h00});
        tbl.push_back('{1, 5'b00111, 40'h1011, 8'h11, 0,  1, 5'b01000, 8'h10, 5'b11101, 40'h1010, 3'd2, 1, 0, 8'h00});
        tbl.push_back('{1, 5'b00110, 40'h1012, 8'h12, 1,  1, 5'b00111, 8'h11, 5'b11001, 40'h1011, 3'd2, 1, 0, 8'h00});
        tbl.push_back('{1, 5'b00011, 40'h1013, 8'h13, 1,  1, 5'b00110, 8'h12, 5'b10001, 40'h1012, 3'd2, 1, 0, 8'h00});
        tbl.push_back('{0, 5'b00000, 40'h0,    8'h00, 1,  1, 5'b00011, 8'h13, 5'b00011, 40'h1013, 3'd1, 1, 0, 8'h00});
        tbl.push_back('{1, 5'b11000, 40'h2000, 8'h5A, 0,  1, 5'b00011, 8'h13, 5'b00011, 40'h1013, 3'd1, 1, 1, 8'h5A});
        tbl.push_back('{0, 5'b00000, 40'h0,    8'h00, 0,  1, 5'b00011, 8'h13, 5'b00011, 40'h1013, 3'd1, 1, 0, 8'h00});
        tbl.push_back('{1, 5'b10101, 40'h2000, 8'h22, 1,  0, 5'b00000, 8'h00, 5'b00000, 40'h0,    3'd0, 1, 1, 8'h22});
        tbl.push_back('{0, 5'b00000, 40'h0,    8'h00, 0,  0, 5'b00000, 8'h00, 5'b00000, 40'h0,    3'd0, 1, 0, 8'h00});
        tbl.push_back('{1, 5'b00000, 40'h1000, 8'h03, 0,  1, 5'b00000, 8'h03, 5'b10000, 40'h1000, 3'd1, 1, 0, 8'h00});
        for (int k = 0; k < 5; k++)
            tbl.push_back('{0, 5'b00000, 40'h0, 8'h00, 0, 1, 5'b00000, 8'h03, 5'b10000, 40'h1000, 3'd1, 1, 0, 8'h00});
        tbl.push_back('{0, 5'b00000, 40'h0,    8'h00, 1,  0, 5'b00000, 8'h00, 5'b00000, 40'h0,    3'd0, 1, 0, 8'h00});

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].cmd, tbl[i].addr, tbl[i].tag, tbl[i].ordy);
            check($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].e_valid});
            check($sformatf("v%0d_out_cmd", i), {59'd0, out_cmd}, {59'd0, tbl[i].e_cmd});
            check($sformatf("v%0d_out_tag", i), {56'd0, out_tag}, {56'd0, tbl[i].e_tag});
            check($sformatf("v%0d_flags", i), {59'd0, flags()}, {59'd0, tbl[i].e_flags});
            check($sformatf("v%0d_out_addr", i), {24'd0, out_addr}, {24'd0, tbl[i].e_addr});
            check($sformatf("v%0d_out_data", i), out_data,
                  tbl[i].e_valid ? (64'hD000_0000 | {56'd0, tbl[i].e_tag}) : 64'd0);
            check($sformatf("v%0d_out_mask", i), {56'd0, out_mask}, {56'd0, tbl[i].e_tag});
            check($sformatf("v%0d_count", i), {61'd0, count}, {61'd0, tbl[i].e_count});
            check($sformatf("v%0d_req_ready", i), {63'd0, req_ready}, {63'd0, tbl[i].e_rdy});
            check($sformatf("v%0d_nack_valid", i), {63'd0, nack_valid}, {63'd0, tbl[i].e_nack});
            check($sformatf("v%0d_nack_tag", i), {56'd0, nack_tag}, {56'd0, tbl[i].e_ntag});
            $display("vector %0d: cmd=%b tag=0x%0h -> out_valid=%0b out_tag=0x%0h count=%0d",
                     i, tbl[i].cmd, tbl[i].tag, out_valid, out_tag, count);
        end

        // Full FIFO: a dequeue does not open a same-cycle enqueue slot.
        for (int k = 0; k < 4; k++) step(1, 5'b00001, 40'h3000 + 40'(k), 8'(k), 0);
        check("full_count", {61'd0, count}, 64'd4);
        check("full_req_ready", {63'd0, req_ready}, 64'd0);
        check("full_head_tag", {56'd0, out_tag}, 64'd0);
        step(1, 5'b00001, 40'h3009, 8'h09, 1);
        check("full_deq_count", {61'd0, count}, 64'd3);
        check("full_deq_head", {56'd0, out_tag}, 64'd1);
        $display("full: dequeued tag 0, count=%0d", count);
        for (int k = 2; k < 4; k++) begin
            step(0, 5'b00000, 40'h0, 8'h00, 1);
            check($sformatf("drain_tag%0d", k), {56'd0, out_tag}, 64'(k));
        end
        step(0, 5'b00000, 40'h0, 8'h00, 1);
        check("drain_empty", {61'd0, count}, 64'd0);
        $display("drain: in-order tags 1..3, count=%0d", count);

        // Fence: blocks intake until the cycle after the fence entry leaves.
        step(1, 5'b00000, 40'h3100, 8'h01, 0);
        step(1, 5'b00101, 40'h3101, 8'h02, 0);
        check("fence_count", {61'd0, count}, 64'd2);
        check("fence_ready0", {63'd0, req_ready}, 64'd0);
        step(1, 5'b00001, 40'h3104, 8'h04, 1);
        check("fence_head", {56'd0, out_tag}, 64'd2);
        check("fence_ready1", {63'd0, req_ready}, 64'd0);
        check("fence_count1", {61'd0, count}, 64'd1);
        step(1, 5'b00001, 40'h3104, 8'h04, 1);
        check("fence_release_count", {61'd0, count}, 64'd0);
        check("fence_release_ready", {63'd0, req_ready}, 64'd1);
        step(1, 5'b00001, 40'h3104, 8'h04, 0);
        check("post_fence_tag", {56'd0, out_tag}, 64'd4);
        check("post_fence_flags", {59'd0, flags()}, 64'b01001);
        check("post_fence_count", {61'd0, count}, 64'd1);
        $display("fence: tag 4 accepted after flush drained, count=%0d", count);
        step(0, 5'b00000, 40'h0, 8'h00, 1);

        // Prefetch: dropped by the DROP_PREFETCH instance, enqueued by the default one.
        req_valid = 0;
        pf_req_valid = 1; req_cmd = 5'b00010; req_tag = 8'h07;
        @(posedge clock);
        #1;
        pf_req_valid = 0;
        check("pfdrop_pulse", {63'd0, pf_pf_dropped}, 64'd1);
        check("pfdrop_out_valid", {63'd0, pf_out_valid}, 64'd0);
        check("pfdrop_count", {61'd0, pf_count}, 64'd0);
        @(posedge clock);
        #1;
        check("pfdrop_pulse_end", {63'd0, pf_pf_dropped}, 64'd0);
        $display("prefetch drop: pf_dropped pulsed, out_valid=%0b", pf_out_valid);
        step(1, 5'b00010, 40'h4000, 8'h08, 0);
        check("pfkeep_flags", {59'd0, flags()}, 64'b00010);
        check("pfkeep_no_drop", {63'd0, pf_dropped}, 64'd0);
        step(0, 5'b00000, 40'h0, 8'h00, 1);

        // Async reset mid-cycle while three entries are queued behind a fence.
        step(1, 5'b00000, 40'h5001, 8'h01, 0);
        step(1, 5'b00000, 40'h5002, 8'h02, 0);
        step(1, 5'b10100, 40'h5003, 8'h03, 0);
        check("prerst_count", {61'd0, count}, 64'd3);
        check("prerst_ready", {63'd0, req_ready}, 64'd0);
        req_valid = 0;
        #2;
        reset = 1'b1;
        #1;
        check("arst_count", {61'd0, count}, 64'd0);
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_out_tag", {56'd0, out_tag}, 64'd0);
        check("arst_out_addr", {24'd0, out_addr}, 64'd0);
        check("arst_req_ready", {63'd0, req_ready}, 64'd1);
        @(negedge clock);
        reset = 1'b0;
        step(0, 5'b00000, 40'h0, 8'h00, 0);
        check("postrst_ready", {63'd0, req_ready}, 64'd1);
        check("postrst_nack", {63'd0, nack_valid}, 64'd0);
        step(1, 5'b00000, 40'h5005, 8'h05, 0);
        check("postrst_tag", {56'd0, out_tag}, 64'd5);
        check("postrst_count", {61'd0, count}, 64'd1);
        $display("async reset: cleared, then tag 5 accepted, count=%0d", count);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_req_buffer.md
Name: mem_req_buffer

Overview:
- Request-side front end of the data cache; sits directly upstream of the cache pipeline.
- Accepts core memory requests carrying a 5-bit memory-op command (M_XRD, M_XWR, M_PFR, ... M_WOK encodings).
- Validates and classifies each command, then buffers requests in an in-order FIFO.
- Enforces ordering: M_FLUSH_ALL and M_SFENCE drain the FIFO before any further request is accepted.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 40, request address width.
- DATA_W, 64, store/AMO data width.
- TAG_W, 8, request tag width.
- DROP_PREFETCH, 0, when 1, M_PFR/M_PFW are accepted and discarded instead of enqueued.

Ports:
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request offered.
- req_ready  out  1  buffer can accept a request.
- req_cmd  in  5  memory-op command.
- req_addr  in  ADDR_W  address.
- req_data  in  DATA_W  write/AMO data.
- req_mask  in  DATA_W/8  byte mask.
- req_tag  in  TAG_W  request tag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  cache accepts head.
- out_cmd / out_addr / out_data / out_mask / out_tag  out  5/ADDR_W/DATA_W/DATA_W/8/TAG_W  head entry fields.
- out_is_read  out  1  head is XRD, XLR, XSC or AMO.
- out_is_write  out  1  head is XWR, PWR, XSC or AMO.
- out_is_amo  out  1  head is SWAP, XOR, OR, AND, ADD, MIN, MAX, MINU or MAXU.
- out_is_prefetch  out  1  head is PFR or PFW.
- out_is_write_intent  out  1  out_is_write or head is PFW or XLR.
- nack_valid  out  1  one-cycle pulse: illegal command rejected.
- nack_tag  out  TAG_W  tag of the rejected request.
- pf_dropped  out  1  one-cycle pulse: prefetch discarded (DROP_PREFETCH=1 only).
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset values: req_ready=1, out_valid=0, all out_* fields 0, classification flags 0, nack_valid=0, nack_tag=0, pf_dropped=0, count=0, state=RUN.
- Reset mid-operation discards all entries and any pending fence; no pulses are produced.
- Handshakes:
  - Request handshake: req_valid & req_ready.
  - Output handshake: out_valid & out_ready.
  - out_* fields and flags remain stable while out_valid=1 and out_ready=0.
- Legal commands: 00000–10100 and 10111.
  - 10101, 10110 and 11xxx are illegal.
  - An illegal command is accepted (consumes the handshake) and never enqueued.
  - nack_valid=1 with nack_tag=req_tag in the following cycle.
- Prefetches with DROP_PREFETCH=1 are accepted and not enqueued; pf_dropped pulses in the following cycle.
- Classification is computed at enqueue and stored per entry.
- Latency and flow:
  - No bypass: an entry enqueued at edge N is visible on out_valid after edge N.
  - Minimum latency is one cycle.
  - Throughput is one request per cycle in and one per cycle out.
- req_ready = (state==RUN) & (count<DEPTH).
  - When full, a simultaneous dequeue does not enable same-cycle enqueue; req_ready is combinational on registered state only.
- Simultaneous enqueue and dequeue with 0<count<DEPTH: count unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally.
- State machine:
  - RUN: when a legal M_FLUSH_ALL or M_SFENCE is enqueued, go to FENCE.
  - FENCE: req_ready=0. Return to RUN in the cycle after the fence entry's output handshake. At that point the FIFO is necessarily empty, because entries ahead of it have already drained and nothing was enqueued behind it.
- Illegal and dropped requests never enter FENCE.

Test Plan:
- Reset, then enqueue M_XRD addr 0x1000 tag 3 with out_ready=0 → out_valid=1 one cycle later, out_is_read=1, out_is_write=0, count=1; fields held for 5 stall cycles.
- Enqueue 4 M_XWR with tags 0–3 and out_ready=0 → req_ready=0 at count=4. Then assert req_valid and out_ready together → one dequeue (tag 0), no enqueue that cycle, count=3. Subsequent drain is in order: tags 1, 2, 3.
- Enqueue M_XA_ADD, M_XSC, M_XLR, M_PFW → flags (read, write, amo, pf, wint): 11101, 11001, 10001, 00011.
- Enqueue M_XRD tag 1, M_FLUSH_ALL tag 2, then hold M_XWR tag 4 valid → req_ready=0 until the cycle after tag 2 dequeues; tag 4 is accepted on the next cycle.
- req_cmd=11000 tag 0x5A → accepted, nack_valid=1 and nack_tag=0x5A for exactly one cycle, count unchanged. DROP_PREFETCH=1 with M_PFR → pf_dropped pulse, out_valid stays 0.
- Assert reset asynchronously mid-cycle with count=3 and state FENCE → outputs reach reset values immediately; req_ready=1 after reset release.
